// File: rtl/npc_pkg.sv
// Shared types and constants for the decode/execute pipeline.
package npc_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // One ID/EX slot: everything the ALU and write-back need from decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] rs2val;
    logic [XLEN-1:0] imm;
    logic [RIDX-1:0] rs1_idx;
    logic [RIDX-1:0] rs2_idx;
    logic [RIDX-1:0] rd_idx;
    logic            use_imm;
    logic            rd_wen;
    logic [2:0]      func3;
    logic            func;
    logic            sub_en;
  } idex_entry_t;

  // True when a write-back targets this source register; x0 is never forwarded.
  function automatic logic fwd_hit(input logic            wen,
                                   input logic [RIDX-1:0] wb_rd,
                                   input logic [RIDX-1:0] src_idx);
    return wen && (wb_rd != '0) && (wb_rd == src_idx);
  endfunction

endpackage

// File: rtl/idex_fwd.sv
// Combinational write-back forwarding onto one ID/EX entry.
module idex_fwd
  import npc_pkg::*;
(
  input  idex_entry_t     entry_in,
  input  logic            wb_wen,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output idex_entry_t     entry_out
);

  // Replace either source operand with the write-back value on an index match.
  always_comb begin
    entry_out = entry_in;
    if (fwd_hit(wb_wen, wb_rd, entry_in.rs1_idx)) entry_out.op1    = wb_data;
    if (fwd_hit(wb_wen, wb_rd, entry_in.rs2_idx)) entry_out.rs2val = wb_data;
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with a two-entry skid buffer and write-back forwarding.
module idex_stage
  import npc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RIDX-1:0] in_rs1_idx,
  input  logic [RIDX-1:0] in_rs2_idx,
  input  logic [RIDX-1:0] in_rd_idx,
  input  logic            in_use_imm,
  input  logic            in_rd_wen,
  input  logic [2:0]      in_func3,
  input  logic            in_func,
  input  logic            in_sub_en,
  input  logic            wb_wen,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] data_in1,
  output logic [XLEN-1:0] data_in2,
  output logic [2:0]      func3,
  output logic            func,
  output logic            sub_en,
  output logic [RIDX-1:0] out_rd_idx,
  output logic            out_rd_wen
);

  idex_entry_t main_q, skid_q;
  logic        main_v, skid_v;
  idex_entry_t cap_raw, cap_fwd, main_fwd, skid_fwd;
  logic        accept, consume;

  // in_ready comes straight from the skid valid flop so it never depends on out_ready.
  assign in_ready = !skid_v;
  assign accept   = in_valid && in_ready;
  assign consume  = main_v && out_ready;

  // Pack the decode inputs into a slot image before capture forwarding.
  always_comb begin
    cap_raw         = '0;
    cap_raw.pc      = in_pc;
    cap_raw.op1     = in_rs1_data;
    cap_raw.rs2val  = in_rs2_data;
    cap_raw.imm     = in_imm;
    cap_raw.rs1_idx = in_rs1_idx;
    cap_raw.rs2_idx = in_rs2_idx;
    cap_raw.rd_idx  = in_rd_idx;
    cap_raw.use_imm = in_use_imm;
    cap_raw.rd_wen  = in_rd_wen;
    cap_raw.func3   = in_func3;
    cap_raw.func    = in_func;
    cap_raw.sub_en  = in_sub_en;
  end

  idex_fwd u_fwd_cap (
    .entry_in (cap_raw),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .entry_out(cap_fwd)
  );

  idex_fwd u_fwd_main (
    .entry_in (main_q),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .entry_out(main_fwd)
  );

  idex_fwd u_fwd_skid (
    .entry_in (skid_q),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .entry_out(skid_fwd)
  );

  // Slot occupancy: main refills from skid or input on consume; skid only fills behind a stalled main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (consume)      main_v <= skid_v || accept;
      else if (!main_v) main_v <= accept;

      if (consume)                skid_v <= 1'b0;
      else if (accept && main_v)  skid_v <= 1'b1;
    end
  end

  // Slot contents: held entries keep absorbing write-backs, including during a skid-to-main move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (consume && skid_v)                 main_q <= skid_fwd;
      else if ((consume || !main_v) && accept) main_q <= cap_fwd;
      else if (main_v)                       main_q <= main_fwd;

      if (accept && main_v && !consume) skid_q <= cap_fwd;
      else if (skid_v)                  skid_q <= skid_fwd;
    end
  end

  assign out_valid  = main_v;
  assign out_pc     = main_q.pc;
  assign data_in1   = main_q.op1;
  assign data_in2   = main_q.use_imm ? main_q.imm : main_q.rs2val;
  assign func3      = main_q.func3;
  assign func       = main_q.func;
  assign sub_en     = main_q.sub_en;
  assign out_rd_idx = main_q.rd_idx;
  assign out_rd_wen = main_q.rd_wen;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage against an in-order queue model.
module tb_idex_stage;
  import npc_pkg::*;

  logic            clk, rst_n, flush;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [RIDX-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic            in_use_imm, in_rd_wen, in_func, in_sub_en;
  logic [2:0]      in_func3;
  logic            wb_wen;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, data_in1, data_in2;
  logic [2:0]      func3;
  logic            func, sub_en;
  logic [RIDX-1:0] out_rd_idx;
  logic            out_rd_wen;

  idex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_use_imm(in_use_imm), .in_rd_wen(in_rd_wen),
    .in_func3(in_func3), .in_func(in_func), .in_sub_en(in_sub_en),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .data_in1(data_in1), .data_in2(data_in2),
    .func3(func3), .func(func), .sub_en(sub_en),
    .out_rd_idx(out_rd_idx), .out_rd_wen(out_rd_wen)
  );

  // Model instruction: what the ALU should eventually see for one accepted instruction.
  typedef struct {
    logic [31:0] pc, a, b, imm;
    logic [4:0]  s1, s2, rd;
    logic        ui, wen, fn, sb;
    logic [2:0]  f3;
  } instr_t;

  instr_t q[$];
  int compared = 0;
  int mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // A pending write-back replaces a source value whenever it names that nonzero register.
  function automatic instr_t model_wb(input instr_t e);
    instr_t r = e;
    if (wb_wen && wb_rd != 0 && wb_rd == e.s1) r.a = wb_data;
    if (wb_wen && wb_rd != 0 && wb_rd == e.s2) r.b = wb_data;
    return r;
  endfunction

  task automatic checkOutput();
    instr_t h;
    check_val("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check_val("in_ready",  {31'd0, in_ready},  {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      h = q[0];
      check_val("out_pc",     out_pc, h.pc);
      check_val("data_in1",   data_in1, h.a);
      check_val("data_in2",   data_in2, h.ui ? h.imm : h.b);
      check_val("func3",      {29'd0, func3}, {29'd0, h.f3});
      check_val("func",       {31'd0, func}, {31'd0, h.fn});
      check_val("sub_en",     {31'd0, sub_en}, {31'd0, h.sb});
      check_val("out_rd_idx", {27'd0, out_rd_idx}, {27'd0, h.rd});
      check_val("out_rd_wen", {31'd0, out_rd_wen}, {31'd0, h.wen});
    end
  endtask

  // One clock: advance the queue model with the inputs in force at the edge, then check.
  task automatic applyStimulus();
    instr_t n;
    bit acc, con;
    @(posedge clk);
    acc = in_valid && (q.size() < 2);
    con = out_ready && (q.size() > 0);
    if (flush) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      foreach (q[i]) q[i] = model_wb(q[i]);
      if (acc) begin
        n.pc = in_pc; n.a = in_rs1_data; n.b = in_rs2_data; n.imm = in_imm;
        n.s1 = in_rs1_idx; n.s2 = in_rs2_idx; n.rd = in_rd_idx;
        n.ui = in_use_imm; n.wen = in_rd_wen; n.fn = in_func; n.sb = in_sub_en; n.f3 = in_func3;
        q.push_back(model_wb(n));
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [4:0] s1, input logic [4:0] s2,
                             input logic ui);
    in_valid = 1'b1; in_pc = pc; in_rs1_data = a; in_rs2_data = b; in_imm = imm;
    in_rs1_idx = s1; in_rs2_idx = s2; in_rd_idx = 5'd10; in_use_imm = ui;
    in_rd_wen = 1'b1; in_func3 = F3_ADD; in_func = 1'b0; in_sub_en = 1'b0;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_wen = en; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive_instr(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    #2;
    check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("reset_data_in1",  data_in1, 32'd0);
    check_val("reset_data_in2",  data_in2, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] ADDI");
    out_ready = 1'b1;
    drive_instr(32'h100, 32'd5, 32'd99, 32'd7, 5'd1, 5'd2, 1'b1);
    applyStimulus();
    check_val("addi_in1", data_in1, 32'd5);
    check_val("addi_in2", data_in2, 32'd7);
    check_val("addi_f3",  {29'd0, func3}, 32'd0);

    $display("[TB] capture forwarding");
    drive_instr(32'h104, 32'd1, 32'd2, 32'd0, 5'd3, 5'd6, 1'b0);
    drive_wb(1'b1, 5'd3, 32'h1234);
    applyStimulus();
    check_val("cap_fwd_in1", data_in1, 32'h1234);
    drive_instr(32'h108, 32'd1, 32'd2, 32'd0, 5'd0, 5'd6, 1'b0);
    drive_wb(1'b1, 5'd0, 32'h1234);
    applyStimulus();
    check_val("cap_x0_in1", data_in1, 32'd1);
    drive_wb(1'b0, 5'd0, 32'd0);
    in_valid = 1'b0;
    applyStimulus();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    drive_instr(32'h200, 32'd11, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0); applyStimulus();
    drive_instr(32'h204, 32'd22, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0); applyStimulus();
    check_val("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_val("bp_head_a", out_pc, 32'h200);
    drive_instr(32'h208, 32'd33, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0); applyStimulus();
    out_ready = 1'b1;
    applyStimulus();
    check_val("bp_head_b", out_pc, 32'h204);
    applyStimulus();
    check_val("bp_head_c", out_pc, 32'h208);
    in_valid = 1'b0;
    applyStimulus();
    check_val("bp_drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] held-entry forwarding");
    out_ready = 1'b0;
    drive_instr(32'h300, 32'd1, 32'd9, 32'd0, 5'd1, 5'd4, 1'b0);
    applyStimulus();
    check_val("hold_pre", data_in2, 32'd9);
    in_valid = 1'b0;
    drive_wb(1'b1, 5'd4, 32'hFF);
    applyStimulus();
    check_val("hold_fwd", data_in2, 32'hFF);
    drive_wb(1'b0, 5'd0, 32'd0);

    $display("[TB] flush");
    drive_instr(32'h304, 32'd2, 32'd3, 32'd0, 5'd1, 5'd2, 1'b0);
    applyStimulus();
    drive_instr(32'h308, 32'd4, 32'd5, 32'd0, 5'd1, 5'd2, 1'b0);
    flush = 1'b1;
    applyStimulus();
    check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_in_ready",  {31'd0, in_ready},  32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    drive_instr(32'h400, 32'd7, 32'd8, 32'd0, 5'd1, 5'd2, 1'b0); applyStimulus();
    drive_instr(32'h404, 32'd9, 32'd8, 32'd0, 5'd1, 5'd2, 1'b0); applyStimulus();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_val("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("rst_mid_data_in1",  data_in1, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_pc       = $urandom();
      in_rs1_data = $urandom();
      in_rs2_data = $urandom();
      in_imm      = $urandom();
      in_rs1_idx  = 5'($urandom_range(0, 7));
      in_rs2_idx  = 5'($urandom_range(0, 7));
      in_rd_idx   = 5'($urandom_range(0, 31));
      in_use_imm  = 1'($urandom_range(0, 1));
      in_rd_wen   = 1'($urandom_range(0, 1));
      in_func3    = 3'($urandom_range(0, 7));
      in_func     = 1'($urandom_range(0, 1));
      in_sub_en   = 1'($urandom_range(0, 1));
      drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
# idex_stage

Pipeline register between decode and the ALU. It captures decoded operands and controls, selects the immediate or rs2 as operand 2, and applies write-back forwarding, both at capture and while an entry is held. It presents `data_in1`, `data_in2`, `func3`, `func` and `sub_en` to the ALU. A two-entry skid buffer with valid/ready handshakes on both sides sustains one instruction per cycle under downstream back-pressure.

## Interface
- `XLEN`, 32: operand width.
- `RIDX`, 5: register index width.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: decode has an instruction.
- `in_ready` out 1: stage can accept.
- `in_pc` in XLEN: instruction PC, carried through.
- `in_rs1_data`, `in_rs2_data` in XLEN: register-file read values.
- `in_imm` in XLEN: sign-extended immediate.
- `in_rs1_idx`, `in_rs2_idx`, `in_rd_idx` in RIDX: register indices.
- `in_use_imm` in 1: operand 2 is the immediate.
- `in_rd_wen` in 1: instruction writes rd.
- `in_func3` in 3, `in_func` in 1, `in_sub_en` in 1: ALU controls.
- `wb_wen` in 1, `wb_rd` in RIDX, `wb_data` in XLEN: write-back port.
- `out_valid` out 1: ALU operands valid.
- `out_ready` in 1: execute consumes.
- `out_pc` out XLEN.
- `data_in1`, `data_in2` out XLEN.
- `func3` out 3, `func` out 1, `sub_en` out 1.
- `out_rd_idx` out RIDX, `out_rd_wen` out 1.

## Operation
- Two slots: main (drives the outputs) and skid.
- Each slot holds pc, op1, rs2val, imm, the indices, use_imm, rd_wen, func3, func and sub_en.
- `in_ready` = skid slot empty. It is a registered signal, not combinational from `out_ready`.
- Accept when `in_valid && in_ready`:
  - Main empty, or main consumed this cycle with skid empty: the new entry goes to main.
  - Otherwise the new entry goes to skid.
- Consume when `out_valid && out_ready`: skid (if full) moves to main, else main empties.
- Forwarding at capture:
  - If `wb_wen`, `wb_rd != 0` and `wb_rd == in_rs1_idx`, op1 = `wb_data`, else `in_rs1_data`.
  - rs2val is selected the same way using `in_rs2_idx`.
- Forwarding while held: each valid slot not consumed this cycle overwrites op1 and/or rs2val with `wb_data` on an index match under the same conditions. A skid→main move applies the update during the move.
- Index 0 is never forwarded. op1 and rs2val stay as captured for x0.
- `data_in1` = main.op1.
- `data_in2` = main.use_imm ? main.imm : main.rs2val.
- Forwarding updates rs2val even when use_imm is set. This is harmless.
- `flush`: both slots are invalidated at the next edge, and any accept that cycle is discarded. Flush has priority over accept, consume and forward.

## Timing
- Latency: accepted at edge N, `out_valid` high after edge N (one cycle).
- Throughput: one per cycle while `out_ready` is high.
- A single-cycle `out_ready` drop costs no bubble, because the skid slot absorbs the in-flight instruction.
- `in_ready` falls the cycle after skid fills. It rises the cycle after skid drains or after a flush.
- `out_valid` never drops without a consume or a flush.
- Main-slot fields are stable while `out_valid && !out_ready`, except op1/rs2val forwarding updates.
- Reset (async assert, sync use after deassert):
  - Both slot valids are 0, so `out_valid=0` and `in_ready=1`.
  - All data and control outputs read 0.
- Simultaneous events:
  - Accept + consume with skid empty: the new entry goes straight to main, with no bubble.
  - Accept + consume with skid full: impossible, because `in_ready` is 0.
  - Write-back to the same rd as an instruction captured in the same cycle: the forwarded value wins over the register-file value.

## Structure
- Shared package `npc_pkg`:
  - `XLEN` and `RIDX` constants.
  - `F3_ADD` … `F3_AND` func3 encodings.
  - A packed struct `idex_entry_t` with all slot fields.
- Sub-module `idex_fwd`: combinational. It takes an entry plus the wb port and returns the forwarded entry. It is used three times: capture, main hold and skid hold/move.
- The top level holds the two slot registers, their valids and the handshake control.

## Test plan
- Reset mid-stream, with both slots full, `rst_n` pulsed low → `out_valid=0`, `in_ready=1`, `data_in1=0` immediately, with no edge needed.
- ADDI: rs1_data=5, imm=7, use_imm=1, `out_ready=1` → one cycle later `data_in1=5`, `data_in2=7`, `func3=000`, `sub_en=0`.
- Capture forward: rs1_idx=3, rs1_data=1, same-cycle `wb_rd=3`, `wb_data=0x1234` → `data_in1=0x1234`.
- Same scenario with `wb_rd=0` → `data_in1=1`.
- Back-pressure: stream A, B, C with `out_ready=0` for 2 cycles, then 1 → `in_ready` low after B is captured. Output order is A, B, C, with nothing dropped or duplicated.
- Held-entry forward: main stalled with rs2_idx=4, rs2val=9, use_imm=0; write-back rd 4 = 0xFF → `data_in2` becomes 0xFF the next cycle.
- Flush with `in_valid=1` and both slots full → the next cycle `out_valid=0`, `in_ready=1`, and the flushed-cycle instruction never appears.
